// File: rtl/mem_pkg.sv
// Shared constants for the register-array FIFO: default geometry and read-port reset values.
package mem_pkg;

    localparam int unsigned FIFO_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH = 8;

    localparam logic [FIFO_WIDTH-1:0] RD_DATA_RST     = '0;
    localparam logic [FIFO_WIDTH-1:0] RD_DATA_BAR_RST = '1;

endpackage : mem_pkg

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port, no reset.
module fifo_mem
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port returns the pre-edge contents, so a same-cycle write at raddr is not seen.
    assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/reg_fifo.sv
// Single-clock byte FIFO with registered read data, occupancy and sticky error flags.
module reg_fifo
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_data_bar,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] rd_data_bar_q, rd_data_bar_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wp_q),
        .wdata (wr_data),
        .raddr (rp_q),
        .rdata (mem_rdata)
    );

    // Status derives only from the registered count.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A write into a full FIFO is allowed when a read frees the oldest slot in the same cycle.
    assign wr_acc = wr_en && (!full || rd_en);
    assign rd_acc = rd_en && !empty;

    // Next-state for pointers, occupancy, flags and the read-data registers.
    always_comb begin
        wp_d          = wp_q;
        rp_d          = rp_q;
        count_d       = count_q;
        overflow_d    = overflow_q | (wr_en & ~wr_acc);
        underflow_d   = underflow_q | (rd_en & ~rd_acc);
        rd_data_d     = rd_data_q;
        rd_data_bar_d = rd_data_bar_q;
        rd_valid_d    = rd_acc;

        if (wr_acc) begin
            wp_d = wp_q + AW'(1);
        end
        if (rd_acc) begin
            rp_d          = rp_q + AW'(1);
            rd_data_d     = mem_rdata;
            rd_data_bar_d = ~mem_rdata;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers; reset discards contents and cancels any pending rd_valid pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q          <= '0;
            rp_q          <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            rd_data_q     <= {WIDTH{RD_DATA_RST[0]}};
            rd_data_bar_q <= {WIDTH{RD_DATA_BAR_RST[0]}};
            rd_valid_q    <= 1'b0;
        end else begin
            wp_q          <= wp_d;
            rp_q          <= rp_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            rd_data_q     <= rd_data_d;
            rd_data_bar_q <= rd_data_bar_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_data_bar = rd_data_bar_q;
    assign rd_valid    = rd_valid_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule : reg_fifo

// File: tb/tb_reg_fifo.sv
// Directed self-checking bench for reg_fifo.
module tb_reg_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic [7:0] rd_data_bar;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    reg_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_data_bar (rd_data_bar),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        reset   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        do_reset();

        // Reset / idle state
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_rd_bar", 32'(rd_data_bar), 32'hFF);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_udf", 32'(underflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        check("idle_empty", 32'(empty), 32'd1);

        // Fill with 0x11..0x18, drain in order
        for (int i = 0; i < 8; i++) begin
            check("fill_not_full", 32'(full), 32'd0);
            cyc(1'b1, 8'(8'h11 + i), 1'b0);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            check("drain_data", 32'(rd_data), 32'(8'h11 + i));
            check("drain_bar", 32'(rd_data_bar), 32'(8'hEE - i));
            check("drain_valid", 32'(rd_valid), 32'd1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        check("valid_pulse", 32'(rd_valid), 32'd0);
        check("hold_data", 32'(rd_data), 32'h18);

        // Overflow: 9th write rejected
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h11 + i), 1'b0);
        check("pre_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, 8'hAA, 1'b0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            check("ovf_drain", 32'(rd_data), 32'(8'h11 + i));
        end
        check("ovf_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full with simultaneous write/read
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h11 + i), 1'b0);
        cyc(1'b1, 8'h55, 1'b1);
        check("fullrw_data", 32'(rd_data), 32'h11);
        check("fullrw_count", 32'(count), 32'd8);
        check("fullrw_full", 32'(full), 32'd1);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            check("fullrw_drain", 32'(rd_data), 32'(8'h12 + i));
        end
        cyc(1'b0, 8'h00, 1'b1);
        check("fullrw_last", 32'(rd_data), 32'h55);
        check("fullrw_empty", 32'(empty), 32'd1);

        // Underflow when empty
        check("pre_udf", 32'(underflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        check("udf_flag", 32'(underflow), 32'd1);
        check("udf_valid", 32'(rd_valid), 32'd0);
        check("udf_hold", 32'(rd_data), 32'h55);
        cyc(1'b1, 8'h3C, 1'b1);
        check("emptyrw_count", 32'(count), 32'd1);
        check("emptyrw_valid", 32'(rd_valid), 32'd0);
        check("emptyrw_hold", 32'(rd_data), 32'h55);
        cyc(1'b0, 8'h00, 1'b1);
        check("emptyrw_read", 32'(rd_data), 32'h3C);
        check("emptyrw_bar", 32'(rd_data_bar), 32'hC3);
        check("emptyrw_valid2", 32'(rd_valid), 32'd1);

        // Wrap-around at count 4
        do_reset();
        check("rst_clear_ovf", 32'(overflow), 32'd0);
        check("rst_clear_udf", 32'(underflow), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'(8'h44 + i), 1'b1);
            check("wrap_data", 32'(rd_data), 32'(8'h40 + i));
            check("wrap_count", 32'(count), 32'd4);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            check("wrap_tail", 32'(rd_data), 32'(8'h54 + i));
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Mid-stream asynchronous reset with a pending rd_valid
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h71 + i), 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        check("mid_valid_pre", 32'(rd_valid), 32'd1);
        check("mid_count_pre", 32'(count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_count", 32'(count), 32'd0);
        check("mid_valid", 32'(rd_valid), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_rd_data", 32'(rd_data), 32'h00);
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        check("mid_post_udf", 32'(underflow), 32'd1);
        check("mid_post_valid", 32'(rd_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_fifo
